// File: rtl/intr_prio_pkg.sv
// Shared types and helpers for the clocked priority interrupt controller.
// Build option: define INTR_RR_EN for per-group round-robin channel selection.
package intr_prio_pkg;

    // Handshake FSM states
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ASSERT = 1'b1
    } state_t;

    // ceil(log2(n)) clamped to at least one bit so 1- and 2-entry fields stay legal
    function automatic int clog2_min1(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/intr_prio_pick.sv
// NUM_CH-wide priority picker: finds the first set bit at or after 'start',
// wrapping modulo NUM_CH. With start tied to zero it is a plain
// lowest-index-first encoder.
module intr_prio_pick
    import intr_prio_pkg::*;
#(
    parameter int NUM_CH = 9,
    parameter int ID_W   = clog2_min1(NUM_CH)
) (
    input  logic [NUM_CH-1:0] vec,
    input  logic [ID_W-1:0]   start,
    output logic              valid,
    output logic [ID_W-1:0]   idx
);

    logic [NUM_CH-1:0] rot_s;
    logic [ID_W:0]     off_s;
    logic [ID_W:0]     sum_s;

    // Rotate the request vector so that bit 'start' lands at position 0
    always_comb begin
        rot_s = NUM_CH'({vec, vec} >> start);
    end

    // Lowest set bit of the rotated vector gives the offset from 'start'
    always_comb begin
        valid = 1'b0;
        off_s = {(ID_W+1){1'b0}};
        for (int j = 0; j < NUM_CH; j++) begin
            if (!valid && rot_s[j]) begin
                valid = 1'b1;
                off_s = (ID_W+1)'(j);
            end else begin
                valid = valid;
            end
        end
    end

    // Map the offset back to an absolute channel index, wrapping past NUM_CH-1
    always_comb begin
        sum_s = {1'b0, start} + off_s;
        if (sum_s >= (ID_W+1)'(NUM_CH)) begin
            idx = ID_W'(sum_s - (ID_W+1)'(NUM_CH));
        end else begin
            idx = ID_W'(sum_s);
        end
    end

endmodule

// File: rtl/intr_prio_ctrl.sv
// Clocked priority interrupt controller: NUM_GRP groups x NUM_CH channels,
// sticky pending bits, one shared channel mask, fixed group priority
// (group 0 highest) and an IRQ/ACK handshake towards the CPU.
// Build option: INTR_RR_EN adds a per-group round-robin start pointer.
module intr_prio_ctrl
    import intr_prio_pkg::*;
#(
    parameter  int NUM_CH  = 9,
    parameter  int NUM_GRP = 3,
    localparam int GRP_W   = clog2_min1(NUM_GRP),
    localparam int ID_W    = clog2_min1(NUM_CH),
    localparam int TOT     = NUM_GRP * NUM_CH
) (
    input  logic               CK,
    input  logic               RST,
    input  logic [TOT-1:0]     REQ,
    input  logic               MASK_WE,
    input  logic [NUM_CH-1:0]  MASK_D,
    input  logic               ACK,
    output logic               IRQ,
    output logic [GRP_W-1:0]   IRQ_GRP,
    output logic [ID_W-1:0]    IRQ_ID,
    output logic [NUM_GRP-1:0] GRP_ACT,
    output logic [TOT-1:0]     PEND
);

    state_t             state_r;
    logic [TOT-1:0]     pend_r;
    logic [NUM_CH-1:0]  mask_r;
    logic               irq_r;
    logic [GRP_W-1:0]   irq_grp_r;
    logic [ID_W-1:0]    irq_id_r;

    logic [TOT-1:0]     elig_s;
    logic [TOT-1:0]     clr_s;
    logic               ack_fire_s;
    logic [NUM_GRP-1:0] grp_valid_s;
    logic [ID_W-1:0]    grp_idx_s [NUM_GRP];
    logic               win_valid_s;
    logic [GRP_W-1:0]   win_grp_s;
    logic [ID_W-1:0]    win_id_s;

`ifdef INTR_RR_EN
    logic [ID_W-1:0]    ptr_r [NUM_GRP];
`endif

    // Same channel mask applies to every group
    assign elig_s = pend_r & {NUM_GRP{mask_r}};

    // One picker per group; the group-level mux below chooses between them
    for (genvar g = 0; g < NUM_GRP; g++) begin : g_grp
        logic [ID_W-1:0] start_s;
`ifdef INTR_RR_EN
        assign start_s = ptr_r[g];
`else
        assign start_s = {ID_W{1'b0}};
`endif
        intr_prio_pick #(
            .NUM_CH (NUM_CH),
            .ID_W   (ID_W)
        ) u_pick (
            .vec   (elig_s[g*NUM_CH +: NUM_CH]),
            .start (start_s),
            .valid (grp_valid_s[g]),
            .idx   (grp_idx_s[g])
        );
    end

    // Fixed group priority: scan downwards so the lowest active group is kept
    always_comb begin
        win_valid_s = 1'b0;
        win_grp_s   = {GRP_W{1'b0}};
        win_id_s    = {ID_W{1'b0}};
        for (int g = NUM_GRP - 1; g >= 0; g--) begin
            if (grp_valid_s[g]) begin
                win_valid_s = 1'b1;
                win_grp_s   = GRP_W'(g);
                win_id_s    = grp_idx_s[g];
            end else begin
                win_valid_s = win_valid_s;
            end
        end
    end

    // One-hot clear of the presented interrupt when the CPU accepts it
    always_comb begin
        ack_fire_s = (state_r == ASSERT) && ACK;
        clr_s      = {TOT{1'b0}};
        for (int g = 0; g < NUM_GRP; g++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ack_fire_s && (irq_grp_r == GRP_W'(g)) && (irq_id_r == ID_W'(c))) begin
                    clr_s[g*NUM_CH + c] = 1'b1;
                end else begin
                    clr_s[g*NUM_CH + c] = clr_s[g*NUM_CH + c];
                end
            end
        end
    end

    // Sticky pending bits (a new request beats a simultaneous clear) and mask load
    always_ff @(posedge CK) begin
        if (RST) begin
            pend_r <= {TOT{1'b0}};
            mask_r <= {NUM_CH{1'b1}};
        end else begin
            pend_r <= (pend_r & ~clr_s) | REQ;
            if (MASK_WE) begin
                mask_r <= MASK_D;
            end else begin
                mask_r <= mask_r;
            end
        end
    end

    // Handshake FSM: latch a winner in IDLE, hold it unchanged until ACK
    always_ff @(posedge CK) begin
        if (RST) begin
            state_r   <= IDLE;
            irq_r     <= 1'b0;
            irq_grp_r <= {GRP_W{1'b0}};
            irq_id_r  <= {ID_W{1'b0}};
`ifdef INTR_RR_EN
            for (int g = 0; g < NUM_GRP; g++) begin
                ptr_r[g] <= {ID_W{1'b0}};
            end
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (win_valid_s) begin
                        irq_r     <= 1'b1;
                        irq_grp_r <= win_grp_s;
                        irq_id_r  <= win_id_s;
                        state_r   <= ASSERT;
                    end else begin
                        irq_r     <= 1'b0;
                        state_r   <= IDLE;
                    end
                end
                ASSERT: begin
                    if (ACK) begin
                        irq_r   <= 1'b0;
                        state_r <= IDLE;
`ifdef INTR_RR_EN
                        // Next search in the served group starts just after the served channel
                        for (int g = 0; g < NUM_GRP; g++) begin
                            if (irq_grp_r == GRP_W'(g)) begin
                                ptr_r[g] <= (irq_id_r == ID_W'(NUM_CH - 1)) ?
                                            {ID_W{1'b0}} : irq_id_r + ID_W'(1);
                            end else begin
                                ptr_r[g] <= ptr_r[g];
                            end
                        end
`endif
                    end else begin
                        irq_r   <= 1'b1;
                        state_r <= ASSERT;
                    end
                end
                default: begin
                    irq_r   <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign IRQ     = irq_r;
    assign IRQ_GRP = irq_grp_r;
    assign IRQ_ID  = irq_id_r;
    assign GRP_ACT = grp_valid_s;
    assign PEND    = pend_r;

endmodule

// File: tb/tb_intr_prio_ctrl.sv
// Directed self-checking bench for intr_prio_ctrl (NUM_CH=9, NUM_GRP=3).
// Expected round-robin order depends on whether INTR_RR_EN is defined.
module tb_intr_prio_ctrl;

    localparam int NUM_CH  = 9;
    localparam int NUM_GRP = 3;
    localparam int TOT     = NUM_CH * NUM_GRP;

    logic           CK;
    logic           RST;
    logic [TOT-1:0] REQ;
    logic           MASK_WE;
    logic [8:0]     MASK_D;
    logic           ACK;
    logic           IRQ;
    logic [1:0]     IRQ_GRP;
    logic [3:0]     IRQ_ID;
    logic [2:0]     GRP_ACT;
    logic [TOT-1:0] PEND;

    int n_tests = 0;
    int n_fail  = 0;

    intr_prio_ctrl #(
        .NUM_CH  (NUM_CH),
        .NUM_GRP (NUM_GRP)
    ) dut (
        .CK      (CK),
        .RST     (RST),
        .REQ     (REQ),
        .MASK_WE (MASK_WE),
        .MASK_D  (MASK_D),
        .ACK     (ACK),
        .IRQ     (IRQ),
        .IRQ_GRP (IRQ_GRP),
        .IRQ_ID  (IRQ_ID),
        .GRP_ACT (GRP_ACT),
        .PEND    (PEND)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle past it before sampling or driving
    task automatic step();
        @(posedge CK);
        #1;
    endtask

    task automatic ack_once();
        ACK = 1'b1;
        step();
        ACK = 1'b0;
    endtask

    logic [3:0] rr_exp [4];
    int         rr_n;

    initial begin
        RST = 1'b1; REQ = '0; MASK_WE = 1'b0; MASK_D = 9'h000; ACK = 1'b0;
        step();
        step();
        RST = 1'b0;
        check("rst_irq",     32'(IRQ),     32'd0);
        check("rst_pend",    32'(PEND),    32'd0);
        check("rst_grp_act", 32'(GRP_ACT), 32'd0);
        check("rst_irq_grp", 32'(IRQ_GRP), 32'd0);
        check("rst_irq_id",  32'(IRQ_ID),  32'd0);

        // 1. single request on group 1 channel 4
        REQ = 27'd1 << 13;
        step();
        REQ = '0;
        check("t1_pend",    32'(PEND),    32'h0000_2000);
        check("t1_irq_lo",  32'(IRQ),     32'd0);
        check("t1_grp_act", 32'(GRP_ACT), 32'd2);
        step();
        check("t1_irq",     32'(IRQ),     32'd1);
        check("t1_grp",     32'(IRQ_GRP), 32'd1);
        check("t1_id",      32'(IRQ_ID),  32'd4);
        ack_once();
        check("t1_irq_ack", 32'(IRQ),     32'd0);
        check("t1_pend_ack",32'(PEND),    32'd0);
        step();

        // 2. group priority: group 0 channel 2 beats group 2 channel 2
        REQ = (27'd1 << 20) | (27'd1 << 2);
        step();
        REQ = '0;
        check("t2_grp_act", 32'(GRP_ACT), 32'd5);
        check("t2_irq_lo",  32'(IRQ),     32'd0);
        step();
        check("t2_irq_a",   32'(IRQ),     32'd1);
        check("t2_grp_a",   32'(IRQ_GRP), 32'd0);
        check("t2_id_a",    32'(IRQ_ID),  32'd2);
        ack_once();
        check("t2_irq_gap", 32'(IRQ),     32'd0);
        check("t2_pend_mid",32'(PEND),    32'h0010_0000);
        step();
        check("t2_irq_b",   32'(IRQ),     32'd1);
        check("t2_grp_b",   32'(IRQ_GRP), 32'd2);
        check("t2_id_b",    32'(IRQ_ID),  32'd2);
        ack_once();
        check("t2_pend_end",32'(PEND),    32'd0);
        step();

        // 3. masked channel latches but is not eligible
        MASK_WE = 1'b1; MASK_D = 9'h1FE; REQ = 27'd1;
        step();
        MASK_WE = 1'b0; REQ = '0;
        check("t3_pend",     32'(PEND),    32'd1);
        check("t3_grp_act",  32'(GRP_ACT), 32'd0);
        check("t3_irq_lo",   32'(IRQ),     32'd0);
        step();
        check("t3_irq_lo2",  32'(IRQ),     32'd0);
        MASK_WE = 1'b1; MASK_D = 9'h1FF;
        step();
        MASK_WE = 1'b0;
        check("t3_irq_lo3",  32'(IRQ),     32'd0);
        check("t3_grp_act2", 32'(GRP_ACT), 32'd1);
        step();
        check("t3_irq",      32'(IRQ),     32'd1);
        check("t3_id",       32'(IRQ_ID),  32'd0);
        ack_once();
        check("t3_pend_end", 32'(PEND),    32'd0);
        step();

        // 4. no preemption of a presented group 2 channel 5
        REQ = 27'd1 << 23;
        step();
        REQ = '0;
        step();
        check("t4_irq",      32'(IRQ),     32'd1);
        check("t4_grp",      32'(IRQ_GRP), 32'd2);
        check("t4_id",       32'(IRQ_ID),  32'd5);
        REQ = 27'd1;
        step();
        REQ = '0;
        check("t4_pend",     32'(PEND),    32'h0080_0001);
        step();
        check("t4_hold_irq", 32'(IRQ),     32'd1);
        check("t4_hold_grp", 32'(IRQ_GRP), 32'd2);
        check("t4_hold_id",  32'(IRQ_ID),  32'd5);
        ack_once();
        check("t4_irq_gap",  32'(IRQ),     32'd0);
        step();
        check("t4_irq2",     32'(IRQ),     32'd1);
        check("t4_grp2",     32'(IRQ_GRP), 32'd0);
        check("t4_id2",      32'(IRQ_ID),  32'd0);
        ack_once();
        check("t4_pend_end", 32'(PEND),    32'd0);
        step();

        // 5. set beats clear, then reset during ASSERT
        REQ = 27'd1 << 7;
        step();
        step();
        check("t5_irq",      32'(IRQ),     32'd1);
        check("t5_id",       32'(IRQ_ID),  32'd7);
        ack_once();
        check("t5_irq_gap",  32'(IRQ),     32'd0);
        check("t5_pend_set", 32'(PEND),    32'h0000_0080);
        step();
        check("t5_irq_re",   32'(IRQ),     32'd1);
        check("t5_id_re",    32'(IRQ_ID),  32'd7);
        RST = 1'b1;
        step();
        RST = 1'b0; REQ = '0;
        check("t5_rst_irq",  32'(IRQ),     32'd0);
        check("t5_rst_pend", 32'(PEND),    32'd0);
        step();
        check("t5_rst_idle", 32'(IRQ),     32'd0);

        // 6. three held requests in group 0
`ifdef INTR_RR_EN
        rr_exp[0] = 4'd0; rr_exp[1] = 4'd3; rr_exp[2] = 4'd8; rr_exp[3] = 4'd0;
        rr_n = 4;
`else
        rr_exp[0] = 4'd0; rr_exp[1] = 4'd0; rr_exp[2] = 4'd0; rr_exp[3] = 4'd0;
        rr_n = 3;
`endif
        REQ = (27'd1 << 0) | (27'd1 << 3) | (27'd1 << 8);
        step();
        step();
        for (int k = 0; k < rr_n; k++) begin
            check($sformatf("t6_irq_%0d", k), 32'(IRQ),     32'd1);
            check($sformatf("t6_grp_%0d", k), 32'(IRQ_GRP), 32'd0);
            check($sformatf("t6_id_%0d",  k), 32'(IRQ_ID),  32'(rr_exp[k]));
            ack_once();
            check($sformatf("t6_gap_%0d", k), 32'(IRQ),     32'd0);
            step();
        end
        REQ = '0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
